mem_loader: RTL
===============

Name: mem_loader

Overview:
- Host-side initiator for the external load port (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext) of an sram instance; the sram side is the responder.
- Accepts a word stream over valid/ready, writes it to consecutive addresses, reads the region back and compares checksums.
- On a checksum match, drives the cpu enable input high so the pipeline starts from reset state.
- Sits between the test/host harness and the cpu top; one instance per memory (instruction or data).

Parameters:
- DATA_W, 32, word width of stream and memory port.
- CNT_W, 10, width of word_count and the internal word counter.
- MAX_WORDS, 512, largest legal word_count.
- ADDR_STEP, 4, byte increment of addr_ext per word.
- RD_LAT, 1, cycles from ren_ext asserted to valid rdata_ext (1..4).

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr/word_count and begins a load
- base_addr  in  32  byte address of first word
- word_count  in  CNT_W  number of words to load
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader accepts in_data this cycle
- addr_ext  out  32  memory external address
- wen_ext  out  1  memory external write enable
- ren_ext  out  1  memory external read enable
- wdata_ext  out  DATA_W  memory external write data
- rdata_ext  in  DATA_W  memory external read data
- cpu_enable  out  1  drives cpu enable
- done  out  1  one-cycle pulse on successful verify
- error  out  1  sticky error flag
- err_code  out  2  01 = count too large, 10 = checksum mismatch

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (arst_n). All state is cleared asynchronously by reset.
- Reset values: every output is 0; state is IDLE; counters and checksums are 0.
- States: IDLE, WRITE, VERIFY, DRAIN, RUN, ERROR.
- IDLE:
  - On start, latch base_addr and word_count, and clear both checksums.
  - If word_count > MAX_WORDS, go to ERROR with err_code=01.
  - If word_count == 0, go to RUN, pulse done and set cpu_enable next cycle.
  - Otherwise go to WRITE.
- WRITE:
  - in_ready=1.
  - On in_valid&in_ready in the same cycle, drive the following combinationally from registered address/counter: wen_ext=1, wdata_ext=in_data, addr_ext=base_addr+idx*ADDR_STEP.
  - On that same accepted cycle, wr_sum += in_data (mod 2^DATA_W) and idx++.
  - in_valid low: no write, no advance.
  - After the word_count-th accepted word, in_ready drops the next cycle and state goes to VERIFY with idx=0.
- VERIFY:
  - Each cycle: ren_ext=1, addr_ext=base_addr+idx*ADDR_STEP, idx++. Reads are back-to-back.
  - An RD_LAT-deep valid shift register tags returns. On each tagged cycle, rd_sum += rdata_ext.
  - After word_count reads are issued, go to DRAIN.
- DRAIN:
  - Wait until the shift register is empty, i.e. all RD_LAT returns are accumulated.
  - rd_sum == wr_sum: pulse done for 1 cycle and go to RUN.
  - Mismatch: go to ERROR with err_code=10.
- RUN: cpu_enable=1 and all memory strobes are 0.
  - start in RUN: cpu_enable falls in the same cycle start is sampled, and a new load begins as from IDLE.
- ERROR: error=1 and err_code holds; cpu_enable=0. start clears error/err_code and begins a new load.
- start in WRITE/VERIFY/DRAIN is ignored.
- wen_ext and ren_ext are never both 1. wen_ext is never asserted outside WRITE; ren_ext is never asserted outside VERIFY.
- addr_ext arithmetic is 32-bit and wraps modulo 2^32 with no error. addr_ext is 0 when no strobe is active.
- cpu_enable is 0 in all states other than RUN. Reset mid-load returns to IDLE immediately with cpu_enable=0.
- Latency from the last accepted word to done: word_count + RD_LAT + 2 cycles (1 state transition + word_count issue cycles + RD_LAT return cycles + 1 compare cycle).

Test Plan:
- Normal load: base=0x0, count=4, words 0x11,0x22,0x33,0x44 with in_valid held high.
  - Writes to 0x0,0x4,0x8,0xC on 4 consecutive cycles, then 4 reads.
  - done pulses once; cpu_enable=1 thereafter; wr_sum=0xAA.
- Stream gaps: count=3, in_valid toggled 1,0,1,0,1.
  - Exactly 3 wen_ext pulses, each aligned to in_valid=1; addresses base, base+4, base+8.
- Count checks:
  - count=600: error=1, err_code=01, no strobes.
  - count=0: done pulses the cycle after start, and cpu_enable=1.
- Checksum mismatch: bench memory model corrupts word 2 on readback (0x33 returned as 0x34).
  - err_code=10, error=1, cpu_enable=0.
  - A subsequent start with a clean model clears error and ends in RUN.
- Reload and reset:
  - start while in RUN: cpu_enable falls the same cycle and the reload completes.
  - arst_n pulled low during VERIFY: all outputs 0 asynchronously, state IDLE, and no strobes after release.
- RD_LAT=3 build, count=8, base=0xFFFF_FFF8:
  - Addresses wrap to 0x0 after 0xFFFF_FFFC.
  - Reads are issued back-to-back; done arrives 8+3+2 cycles after the last accepted word.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: streams a block of words into an sram external load port, reads the
// block back, compares checksums and only then releases the cpu enable.
module mem_loader #(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 10,
   parameter int MAX_WORDS = 512,
   parameter int ADDR_STEP = 4,
   parameter int RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic [31:0]       base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [31:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [DATA_W-1:0] wdata_ext,
   input  logic [DATA_W-1:0] rdata_ext,
   output logic              cpu_enable,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, RUN, ERROR} state_t;

   state_t              state_q, state_d;
   logic [31:0]         base_q;
   logic [CNT_W-1:0]    cnt_q, idx_q;
   logic [DATA_W-1:0]   wr_sum_q, rd_sum_q;
   logic [RD_LAT-1:0]   vld_pipe;
   logic [1:0]          err_q;
   logic                done_q;
   logic                load, too_big, accept, last_idx, done_set, pipe_empty;
   logic [31:0]         idx_addr;

   // A new load is only honoured from the resting states; mid-load starts are dropped.
   assign load       = start && (state_q inside {IDLE, RUN, ERROR});
   assign too_big    = int'(word_count) > MAX_WORDS;
   assign last_idx   = (idx_q == cnt_q - CNT_W'(1));
   assign pipe_empty = (vld_pipe == '0);
   assign idx_addr   = base_q + 32'(idx_q) * 32'(ADDR_STEP);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      done_set = 1'b0;
      unique case (state_q)
         IDLE, RUN, ERROR:
            if (start) begin
               if (too_big)                 state_d = ERROR;
               else if (word_count == '0) begin
                  state_d  = RUN;
                  done_set = 1'b1;
               end else                     state_d = WRITE;
            end
         WRITE:  if (accept && last_idx) state_d = VERIFY;
         VERIFY: if (last_idx)           state_d = DRAIN;
         DRAIN:
            if (pipe_empty) begin
               if (rd_sum_q == wr_sum_q) begin
                  state_d  = RUN;
                  done_set = 1'b1;
               end else state_d = ERROR;
            end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state_q == WRITE);
      accept     = in_ready && in_valid;
      wen_ext    = accept;
      ren_ext    = (state_q == VERIFY);
      addr_ext   = (wen_ext || ren_ext) ? idx_addr : 32'h0;
      wdata_ext  = accept ? in_data : '0;
      // Drop the enable in the very cycle a reload is requested from RUN.
      cpu_enable = (state_q == RUN) && !start;
      error      = (state_q == ERROR);
      err_code   = err_q;
      done       = done_q;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         base_q   <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         wr_sum_q <= '0;
         rd_sum_q <= '0;
         vld_pipe <= '0;
         err_q    <= 2'b00;
         done_q   <= 1'b0;
      end else begin
         done_q   <= done_set;
         vld_pipe <= (vld_pipe << 1) | RD_LAT'(ren_ext);
         if (vld_pipe[RD_LAT-1]) rd_sum_q <= rd_sum_q + rdata_ext;
         if (accept) begin
            wr_sum_q <= wr_sum_q + in_data;
            idx_q    <= last_idx ? '0 : idx_q + CNT_W'(1);
         end else if (state_q == VERIFY) begin
            idx_q    <= last_idx ? '0 : idx_q + CNT_W'(1);
         end
         if (state_q == DRAIN && pipe_empty && rd_sum_q != wr_sum_q) err_q <= 2'b10;
         if (load) begin
            base_q   <= base_addr;
            cnt_q    <= word_count;
            idx_q    <= '0;
            wr_sum_q <= '0;
            rd_sum_q <= '0;
            err_q    <= too_big ? 2'b01 : 2'b00;
         end
      end
   end

endmodule
